// File: rtl/sat_block_accumulator.sv
// Saturating block accumulator: sums BLOCK_LEN signed samples with a clamp on every step,
// then holds one block result and a sticky saturation flag until the sink accepts it.
module sat_block_accumulator #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sat,
   output logic              busy
);

   // state | meaning
   // ACCUM | accepting samples into acc
   // HOLD  | block result presented, waiting for out_ready
   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic [CNT_W-1:0]   count, count_nx;
   logic               sat_flag, sat_flag_nx;
   logic [ACC_W-1:0]   out_data_nx;
   logic               out_sat_nx, out_valid_nx;

   logic [ACC_W:0]     in_ext, acc_ext, sum;
   logic [ACC_W-1:0]   result;
   logic               step_sat;

   // The two top sum bits disagree exactly when the ACC_W-bit range is exceeded.
   always_comb begin
      in_ext   = {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
      acc_ext  = {acc[ACC_W-1], acc};
      sum      = acc_ext + in_ext;
      step_sat = sum[ACC_W] ^ sum[ACC_W-1];
      if (!step_sat)
         result = sum[ACC_W-1:0];
      else if (sum[ACC_W])
         result = ACC_MIN;
      else
         result = ACC_MAX;
   end

   assign in_ready = (state == ACCUM);
   assign busy     = (count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ACCUM;
         acc       <= '0;
         count     <= '0;
         sat_flag  <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         count     <= count_nx;
         sat_flag  <= sat_flag_nx;
         out_data  <= out_data_nx;
         out_sat   <= out_sat_nx;
         out_valid <= out_valid_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      count_nx     = count;
      sat_flag_nx  = sat_flag;
      out_data_nx  = out_data;
      out_sat_nx   = out_sat;
      out_valid_nx = out_valid;
      if (clear) begin
         acc_nx       = '0;
         count_nx     = '0;
         sat_flag_nx  = 1'b0;
         out_valid_nx = 1'b0;
         state_nx     = ACCUM;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  if (count == CNT_LAST) begin
                     out_data_nx  = result;
                     out_sat_nx   = sat_flag | step_sat;
                     out_valid_nx = 1'b1;
                     acc_nx       = '0;
                     count_nx     = '0;
                     sat_flag_nx  = 1'b0;
                     state_nx     = HOLD;
                  end else begin
                     acc_nx      = result;
                     sat_flag_nx = sat_flag | step_sat;
                     count_nx    = count + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid_nx = 1'b0;
                  state_nx     = ACCUM;
               end
            end
            default: state_nx = ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_sat_block_accumulator.sv
// Directed bench for sat_block_accumulator with hand-computed block results.
module tb_sat_block_accumulator;

   logic       clk;
   logic       reset;
   logic       clear;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_sat;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   sat_block_accumulator #(
      .DATA_W(8), .ACC_W(8), .BLOCK_LEN(4), .CNT_W(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one sample for one edge; returns at edge+1.
   task automatic feed(input logic [7:0] s);
      in_valid = 1'b1;
      in_data  = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic block(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      feed(a);
      feed(b);
      feed(c);
      feed(d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_sat",   32'(out_sat),   32'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy",     32'(busy),     32'd0);

      // nominal 3,3,3,3 with sink always ready
      out_ready = 1'b1;
      feed(8'd3);
      check("nom_busy1", 32'(busy), 32'd1);
      feed(8'd3);
      feed(8'd3);
      feed(8'd3);
      check("nom_valid",    32'(out_valid), 32'd1);
      check("nom_data",     32'(out_data),  32'd12);
      check("nom_sat",      32'(out_sat),   32'd0);
      check("nom_in_ready", 32'(in_ready),  32'd0);
      check("nom_busy0",    32'(busy),      32'd0);
      tick();
      check("nom_valid_drop",  32'(out_valid), 32'd0);
      check("nom_in_ready_up", 32'(in_ready),  32'd1);

      // positive clamp: 100, 127(c), 107, 97
      block(8'd100, 8'd50, 8'hEC, 8'hF6);
      check("pos_data", 32'(out_data), 32'd97);
      check("pos_sat",  32'(out_sat),  32'd1);
      tick();

      // negative clamp: -128, -128(c), -123, -123
      block(8'h80, 8'h80, 8'd5, 8'd0);
      check("neg_data", 32'(out_data), 32'h85);
      check("neg_sat",  32'(out_sat),  32'd1);
      tick();
      block(8'd1, 8'd1, 8'd1, 8'd1);
      check("neg_next_data", 32'(out_data), 32'd4);
      check("neg_next_sat",  32'(out_sat),  32'd0);
      tick();

      // backpressure with ignored input pulses
      out_ready = 1'b0;
      block(8'd3, 8'd3, 8'd3, 8'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'd99;
         tick();
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_data",     32'(out_data),  32'd12);
         check("bp_in_ready", 32'(in_ready),  32'd0);
         check("bp_busy",     32'(busy),      32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready),  32'd1);
      check("bp_release_busy",  32'(busy),      32'd0);

      // clear mid-block drops the coincident sample
      feed(8'd10);
      feed(8'd10);
      check("clr_busy_pre", 32'(busy), 32'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd50;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_busy",  32'(busy),      32'd0);
      check("clr_valid", 32'(out_valid), 32'd0);
      block(8'd1, 8'd1, 8'd1, 8'd1);
      check("clr_after_data",  32'(out_data), 32'd4);
      check("clr_after_sat",   32'(out_sat),  32'd0);
      tick();

      // clear in HOLD discards the held result
      out_ready = 1'b0;
      block(8'd5, 8'd5, 8'd5, 8'd5);
      check("clrh_data", 32'(out_data), 32'd20);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clrh_valid",    32'(out_valid), 32'd0);
      check("clrh_in_ready", 32'(in_ready),  32'd1);

      // async reset while holding a saturated result
      block(8'd100, 8'd100, 8'd0, 8'd0);
      check("ar_pre_data",  32'(out_data),  32'd127);
      check("ar_pre_sat",   32'(out_sat),   32'd1);
      check("ar_pre_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_valid", 32'(out_valid), 32'd0);
      check("ar_data",  32'(out_data),  32'd0);
      check("ar_sat",   32'(out_sat),   32'd0);
      #1;
      reset = 1'b0;
      #1;
      check("ar_in_ready", 32'(in_ready), 32'd1);
      check("ar_busy",     32'(busy),     32'd0);
      out_ready = 1'b1;
      block(8'd2, 8'd2, 8'd2, 8'd2);
      check("ar_after_valid", 32'(out_valid), 32'd1);
      check("ar_after_data",  32'(out_data),  32'd8);
      check("ar_after_sat",   32'(out_sat),   32'd0);
      tick();
      check("ar_after_drop", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
